// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: host FSM states, host opcodes
// and the burst-length saturation helper.
package dmem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_DATA,
    DONE
  } state_t;

  localparam logic HOST_OP_WR = 1'b0;
  localparam logic HOST_OP_RD = 1'b1;

  // Clamp a requested burst length to the array depth (2^aw words).
  function automatic logic [31:0] sat_len(input logic [31:0] len, input int unsigned aw);
    logic [31:0] depth;
    depth = 32'd1 << aw;
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 2^AW x DW, registered read-first output.
// Contents are never cleared.
module dmem_array #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// CPU data-port responder over a 256x16 store, plus a host burst port that
// preloads/dumps the array while the CPU is disabled.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_dataout,
  input  logic          d_we,
  output logic [DW-1:0] d_datain,
  input  logic          host_start,
  input  logic          host_op,
  input  logic [AW-1:0] host_base,
  input  logic [AW:0]   host_len,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_wvalid,
  output logic          host_wready,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  input  logic          host_rready,
  output logic          host_busy,
  output logic          host_done
);

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [AW:0]   remain_q, remain_nxt;
  logic [AW:0]   len_sat;

  logic          arr_we;
  logic [AW-1:0] arr_addr;
  logic [DW-1:0] arr_wdata;
  logic [DW-1:0] arr_rdata;

  logic          cpu_load_q;
  logic          rd_fresh_q;
  logic [DW-1:0] d_hold_q;
  logic [DW-1:0] r_hold_q;
  logic          wr_accept;

  assign len_sat     = (AW+1)'(sat_len(32'(host_len), AW));
  assign host_wready = (state == WR) && !enable;
  assign wr_accept   = host_wready && host_wvalid;
  assign host_rvalid = (state == RD_DATA);
  assign host_busy   = (state != IDLE);
  assign host_done   = (state == DONE);

  // The array output is only trusted on the cycle right after the read that
  // produced it; otherwise each port replays its own held copy, so the other
  // owner may reuse the array without disturbing it.
  assign d_datain   = cpu_load_q ? arr_rdata : d_hold_q;
  assign host_rdata = rd_fresh_q ? arr_rdata : r_hold_q;

  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = addr_q;
    arr_wdata = host_wdata;
    if (enable) begin
      arr_we    = d_we;
      arr_addr  = d_addr;
      arr_wdata = d_dataout;
    end else begin
      arr_we    = wr_accept;
    end
  end

  dmem_array #(
    .AW(AW),
    .DW(DW)
  ) u_array (
    .clock (clock),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    remain_nxt = remain_q;
    case (state)
      IDLE: begin
        if (host_start) begin
          addr_nxt   = host_base;
          remain_nxt = len_sat;
          if (len_sat == '0) begin
            state_nxt = DONE;
          end else if (host_op == HOST_OP_RD) begin
            state_nxt = RD_ISSUE;
          end else begin
            state_nxt = WR;
          end
        end
      end
      WR: begin
        if (wr_accept) begin
          addr_nxt   = addr_q + 1'b1;
          remain_nxt = remain_q - 1'b1;
          if (remain_q == (AW+1)'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      RD_ISSUE: begin
        if (!enable) begin
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        if (host_rready) begin
          addr_nxt   = addr_q + 1'b1;
          remain_nxt = remain_q - 1'b1;
          state_nxt  = (remain_q == (AW+1)'(1)) ? DONE : RD_ISSUE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      cpu_load_q <= 1'b0;
      rd_fresh_q <= 1'b0;
      d_hold_q   <= '0;
      r_hold_q   <= '0;
    end else begin
      state      <= state_nxt;
      addr_q     <= addr_nxt;
      remain_q   <= remain_nxt;
      cpu_load_q <= enable && !d_we;
      rd_fresh_q <= (state == RD_ISSUE) && !enable;
      // Stores bypass the array (write-first); otherwise keep what is shown.
      d_hold_q   <= (enable && d_we) ? d_dataout : d_datain;
      r_hold_q   <= host_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl against a word-array reference model.
module tb_dmem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  d_addr;
  logic [15:0] d_dataout;
  logic        d_we;
  logic [15:0] d_datain;
  logic        host_start;
  logic        host_op;
  logic [7:0]  host_base;
  logic [8:0]  host_len;
  logic [15:0] host_wdata;
  logic        host_wvalid;
  logic        host_wready;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic        host_rready;
  logic        host_busy;
  logic        host_done;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [256];
  logic [15:0] wq [$];

  always #5 clock = ~clock;

  dmem_ctrl #(.AW(8), .DW(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .d_addr      (d_addr),
    .d_dataout   (d_dataout),
    .d_we        (d_we),
    .d_datain    (d_datain),
    .host_start  (host_start),
    .host_op     (host_op),
    .host_base   (host_base),
    .host_len    (host_len),
    .host_wdata  (host_wdata),
    .host_wvalid (host_wvalid),
    .host_wready (host_wready),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .host_rready (host_rready),
    .host_busy   (host_busy),
    .host_done   (host_done)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_off();
    enable = 1'b0;
    d_we   = 1'b0;
  endtask

  task automatic cpu_load(input logic [7:0] a);
    enable = 1'b1; d_we = 1'b0; d_addr = a;
    step();
    checks++;
    if (d_datain !== model[a]) begin
      errors++;
      $display("FAIL cpu_load addr=%h got=%h exp=%h", a, d_datain, model[a]);
    end
  endtask

  task automatic cpu_store(input logic [7:0] a, input logic [15:0] v);
    enable = 1'b1; d_we = 1'b1; d_addr = a; d_dataout = v;
    step();
    model[a] = v;
    checks++;
    if (d_datain !== v) begin
      errors++;
      $display("FAIL cpu_store_bypass addr=%h got=%h exp=%h", a, d_datain, v);
    end
  endtask

  // Write burst from wq with wvalid held high and the CPU disabled.
  task automatic host_wr(input logic [7:0] base, input logic [8:0] len);
    int n;
    n = (len > 9'd256) ? 256 : int'(len);
    host_start = 1'b1; host_op = 1'b0; host_base = base; host_len = len;
    host_wvalid = 1'b0;
    step();
    host_start = 1'b0;
    checks++;
    if (host_busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_busy_c1 got=%b exp=1", host_busy);
    end
    for (int k = 0; k < n; k++) begin
      host_wvalid = 1'b1;
      host_wdata  = wq[k];
      #1;
      checks++;
      if (host_wready !== 1'b1) begin
        errors++;
        $display("FAIL wr_ready word=%0d got=%b exp=1", k, host_wready);
      end
      step();
      model[(int'(base) + k) % 256] = wq[k];
    end
    host_wvalid = 1'b0;
    checks++;
    if (host_done !== 1'b1) begin
      errors++;
      $display("FAIL wr_done_cycle%0d got=%b exp=1", n + 1, host_done);
    end
    step();
    checks++;
    if (host_done !== 1'b0 || host_busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_after_done done=%b busy=%b exp=0/0", host_done, host_busy);
    end
  endtask

  // Read burst with rready held high: word k appears in cycle 2k+2.
  task automatic host_rd(input logic [7:0] base, input logic [8:0] len);
    int n;
    logic [15:0] exp_w;
    n = (len > 9'd256) ? 256 : int'(len);
    host_start = 1'b1; host_op = 1'b1; host_base = base; host_len = len;
    host_rready = 1'b1;
    step();
    host_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (host_rvalid !== 1'b0 || host_busy !== 1'b1) begin
        errors++;
        $display("FAIL rd_issue word=%0d rvalid=%b busy=%b exp=0/1", k, host_rvalid, host_busy);
      end
      step();
      exp_w = model[(int'(base) + k) % 256];
      checks++;
      if (host_rvalid !== 1'b1 || host_rdata !== exp_w) begin
        errors++;
        $display("FAIL rd_word word=%0d rvalid=%b got=%h exp=%h", k, host_rvalid, host_rdata, exp_w);
      end
      step();
    end
    checks++;
    if (host_done !== 1'b1) begin
      errors++;
      $display("FAIL rd_done_cycle%0d got=%b exp=1", 2 * n + 1, host_done);
    end
    step();
    host_rready = 1'b0;
    checks++;
    if (host_done !== 1'b0 || host_busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_after_done done=%b busy=%b exp=0/0", host_done, host_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; d_addr = '0; d_dataout = '0; d_we = 1'b0;
    host_start = 1'b0; host_op = 1'b0; host_base = '0; host_len = '0;
    host_wdata = '0; host_wvalid = 1'b0; host_rready = 1'b0;
    step();
    step();
    checks++;
    if (d_datain !== 16'h0 || host_rdata !== 16'h0 || host_rvalid !== 1'b0 ||
        host_done !== 1'b0 || host_busy !== 1'b0 || host_wready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state d_datain=%h rdata=%h rvalid=%b done=%b busy=%b wready=%b exp=all0",
               d_datain, host_rdata, host_rvalid, host_done, host_busy, host_wready);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_preload_saturate();
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back(16'($urandom));
    host_wr(8'h00, 9'd300);
    host_rd(8'h80, 9'd400);
  endtask

  task automatic test_write_then_cpu_load();
    wq = '{16'h00AB, 16'h3C00};
    host_wr(8'h00, 9'd2);
    cpu_load(8'h00);
    cpu_load(8'h01);
    cpu_off();
  endtask

  task automatic test_back_to_back();
    cpu_store(8'h02, 16'h3CAB);
    cpu_load(8'h02);
    cpu_off();
  endtask

  task automatic test_hold_when_disabled();
    logic [15:0] shown;
    cpu_load(8'h05);
    shown = model[8'h05];
    enable = 1'b0; d_we = 1'b1; d_addr = 8'h05; d_dataout = ~shown;
    step();
    step();
    checks++;
    if (d_datain !== shown) begin
      errors++;
      $display("FAIL hold_disabled got=%h exp=%h", d_datain, shown);
    end
    d_we = 1'b0;
    cpu_load(8'h05);
    cpu_off();
  endtask

  task automatic test_wrap_read();
    wq = '{16'h1111, 16'h2222, 16'h3333};
    host_wr(8'hFE, 9'd3);
    host_rd(8'hFE, 9'd3);
  endtask

  task automatic test_rready_stall();
    logic [15:0] first;
    host_start = 1'b1; host_op = 1'b1; host_base = 8'h30; host_len = 9'd2;
    host_rready = 1'b0;
    step();
    host_start = 1'b0;
    step();
    first = model[8'h30];
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== first) begin
      errors++;
      $display("FAIL stall_first rvalid=%b got=%h exp=%h", host_rvalid, host_rdata, first);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin host_start = 1'b1; host_op = 1'b0; host_len = 9'd5; end
      if (i == 1) begin host_start = 1'b0; enable = 1'b1; d_we = 1'b0; d_addr = 8'h31; end
      if (i == 3) cpu_off();
      step();
      checks++;
      if (host_rvalid !== 1'b1 || host_rdata !== first) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d rvalid=%b got=%h exp=%h", i, host_rvalid, host_rdata, first);
      end
    end
    host_rready = 1'b1;
    step();
    step();
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== model[8'h31]) begin
      errors++;
      $display("FAIL stall_second rvalid=%b got=%h exp=%h", host_rvalid, host_rdata, model[8'h31]);
    end
    step();
    checks++;
    if (host_done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done got=%b exp=1", host_done);
    end
    host_rready = 1'b0;
    step();
    checks++;
    if (host_busy !== 1'b0 || host_done !== 1'b0) begin
      errors++;
      $display("FAIL stall_ignored_start busy=%b done=%b exp=0/0", host_busy, host_done);
    end
  endtask

  task automatic test_enable_pause();
    logic [15:0] w [4];
    logic [15:0] s;
    for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
    s = 16'($urandom);
    host_start = 1'b1; host_op = 1'b0; host_base = 8'h40; host_len = 9'd4;
    step();
    host_start = 1'b0;
    host_wvalid = 1'b1; host_wdata = w[0];
    #1;
    checks++;
    if (host_wready !== 1'b1) begin
      errors++;
      $display("FAIL pause_ready0 got=%b exp=1", host_wready);
    end
    step();
    model[8'h40] = w[0];
    host_wdata = w[1];
    enable = 1'b1; d_we = 1'b1; d_addr = 8'h80; d_dataout = s;
    #1;
    checks++;
    if (host_wready !== 1'b0) begin
      errors++;
      $display("FAIL pause_ready_drop got=%b exp=0", host_wready);
    end
    step();
    model[8'h80] = s;
    d_we = 1'b0;
    #1;
    checks++;
    if (host_wready !== 1'b0 || d_datain !== s) begin
      errors++;
      $display("FAIL pause_store wready=%b d_datain=%h exp=0/%h", host_wready, d_datain, s);
    end
    step();
    checks++;
    if (d_datain !== s || host_busy !== 1'b1 || host_done !== 1'b0) begin
      errors++;
      $display("FAIL pause_load d_datain=%h busy=%b done=%b exp=%h/1/0", d_datain, host_busy, host_done, s);
    end
    cpu_off();
    for (int k = 1; k < 4; k++) begin
      host_wdata = w[k];
      #1;
      checks++;
      if (host_wready !== 1'b1) begin
        errors++;
        $display("FAIL pause_resume word=%0d got=%b exp=1", k, host_wready);
      end
      step();
      model[8'h40 + k] = w[k];
    end
    host_wvalid = 1'b0;
    checks++;
    if (host_done !== 1'b1) begin
      errors++;
      $display("FAIL pause_done got=%b exp=1", host_done);
    end
    step();
    for (int k = 0; k < 4; k++) cpu_load(8'(8'h40 + k));
    cpu_load(8'h80);
    cpu_off();
  endtask

  task automatic test_len_zero();
    wq.delete();
    host_wr(8'h12, 9'd0);
    host_rd(8'h34, 9'd0);
    cpu_load(8'h12);
    cpu_off();
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          int n;
          n = $urandom_range(0, 12);
          wq.delete();
          for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
          host_wr(8'($urandom), 9'(n));
        end
        1: host_rd(8'($urandom), 9'($urandom_range(0, 12)));
        default: begin
          for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) cpu_store(8'($urandom), 16'($urandom));
            else cpu_load(8'($urandom));
          end
          cpu_off();
        end
      endcase
    end
  endtask

  task automatic test_reset_in_rd_data();
    host_start = 1'b1; host_op = 1'b1; host_base = 8'h10; host_len = 9'd3;
    host_rready = 1'b0;
    step();
    host_start = 1'b0;
    step();
    checks++;
    if (host_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_rd_pre rvalid=%b exp=1", host_rvalid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (host_rvalid !== 1'b0 || host_busy !== 1'b0 || host_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_rd_post rvalid=%b busy=%b done=%b exp=0/0/0", host_rvalid, host_busy, host_done);
    end
    for (int i = 0; i < 4; i++) begin
      host_rready = 1'b1;
      step();
      checks++;
      if (host_done !== 1'b0 || host_busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_rd_abandon cyc=%0d done=%b busy=%b exp=0/0", i, host_done, host_busy);
      end
    end
    host_rready = 1'b0;
    host_rd(8'h10, 9'd2);
  endtask

  initial begin
    test_reset();
    test_preload_saturate();
    test_write_then_cpu_load();
    test_back_to_back();
    test_hold_when_disabled();
    test_wrap_read();
    test_rready_stall();
    test_enable_pause();
    test_len_zero();
    test_random();
    test_reset_in_rd_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
